// File: rtl/syn_hazard_scoreboard.sv
// syn_hazard_scoreboard
// Tracks destination registers of instructions in flight after ID and
// resolves, for each source operand of the instruction in ID, whether its
// value can be forwarded (registered select for EX) or whether a load-use
// style bubble is needed (combinational request). Also keeps saturating
// counters of bubble cycles and of issued instructions that forward.
module syn_hazard_scoreboard #(
  parameter int SLOTS    = 3,
  parameter int NUM_SRC  = 2,
  parameter int REG_BITS = 5,
  parameter int SEL_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         stall_in,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [NUM_SRC*REG_BITS-1:0]  id_src,
  input  logic [NUM_SRC-1:0]           id_src_used,
  input  logic                         id_w_en,
  input  logic [REG_BITS-1:0]          id_req_w,
  input  logic [1:0]                   id_lat,
  output logic                         bubble,
  output logic [NUM_SRC*SEL_BITS-1:0]  fwd_sel,
  output logic [SLOTS-1:0]             slot_valid,
  output logic [CNT_BITS-1:0]          stall_count,
  output logic [CNT_BITS-1:0]          fwd_count
);

  // Slot k (1 = youngest). Only the valid bit is reset; the payload is
  // meaningless while its valid bit is low.
  logic [SLOTS:1]      r_vld;
  logic [SLOTS:1]      r_wen;
  logic [REG_BITS-1:0] r_dest [1:SLOTS];
  logic [1:0]          r_lat  [1:SLOTS];

  logic [NUM_SRC*SEL_BITS-1:0] r_fwd_sel;
  logic [CNT_BITS-1:0]         r_stall_cnt;
  logic [CNT_BITS-1:0]         r_fwd_cnt;

  logic [NUM_SRC*SEL_BITS-1:0] w_sel;
  logic [NUM_SRC-1:0]          w_haz;
  logic                        w_bubble;
  logic                        w_issue;
  logic                        w_any_fwd;

  function automatic logic [CNT_BITS-1:0] f_sat_inc(input logic [CNT_BITS-1:0] c);
    f_sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  // Per-source match search: scan oldest matchable slot first so the
  // youngest match overwrites and wins. The WB slot (SLOTS) is excluded
  // because the register file is written before it is read.
  always_comb begin
    w_sel = '0;
    w_haz = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = SLOTS - 1; k >= 1; k--) begin
        if (id_src_used[i] && r_vld[k] && r_wen[k] && (r_dest[k] != '0) &&
            (r_dest[k] == id_src[i*REG_BITS +: REG_BITS])) begin
          if (k < int'(r_lat[k])) begin
            w_haz[i]                        = 1'b1;
            w_sel[i*SEL_BITS +: SEL_BITS]   = '0;
          end else begin
            w_haz[i]                        = 1'b0;
            w_sel[i*SEL_BITS +: SEL_BITS]   = SEL_BITS'(k + 1);
          end
        end
      end
    end
  end

  assign w_bubble  = id_valid & (|w_haz) & ~flush;
  assign w_issue   = id_valid & ~w_bubble & ~stall_in & ~flush;
  assign w_any_fwd = |w_sel;

  // Control state: slot occupancy, registered selects and event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= '0;
      r_fwd_sel   <= '0;
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (en) begin
      r_vld     <= {r_vld[SLOTS-1:1], w_issue};
      r_fwd_sel <= w_issue ? w_sel : '0;
      if (w_bubble) begin
        r_stall_cnt <= f_sat_inc(r_stall_cnt);
      end
      if (w_issue && w_any_fwd) begin
        r_fwd_cnt <= f_sat_inc(r_fwd_cnt);
      end
    end
  end

  // Slot payload shifts with the valid bits; slot 1 captures ID fields.
  always_ff @(posedge clk) begin
    if (en) begin
      r_wen[1]  <= id_w_en;
      r_dest[1] <= id_req_w;
      r_lat[1]  <= id_lat;
      for (int k = SLOTS; k >= 2; k--) begin
        r_wen[k]  <= r_wen[k-1];
        r_dest[k] <= r_dest[k-1];
        r_lat[k]  <= r_lat[k-1];
      end
    end
  end

  assign bubble      = w_bubble;
  assign fwd_sel     = r_fwd_sel;
  assign slot_valid  = r_vld;
  assign stall_count = r_stall_cnt;
  assign fwd_count   = r_fwd_cnt;

endmodule

// File: tb/tb_syn_hazard_scoreboard.sv
// Directed bench for syn_hazard_scoreboard (SLOTS=3, NUM_SRC=2, CNT_BITS=4).
// Expected fwd_sel values are queued when an instruction is driven and
// compared after the following clock edge.
module tb_syn_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall_in;
  logic        flush;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_w_en;
  logic [4:0]  id_req_w;
  logic [1:0]  id_lat;
  logic        bubble;
  logic [5:0]  fwd_sel;
  logic [2:0]  slot_valid;
  logic [3:0]  stall_count;
  logic [3:0]  fwd_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] q_sel [$];

  syn_hazard_scoreboard #(
    .SLOTS(3), .NUM_SRC(2), .REG_BITS(5), .SEL_BITS(3), .CNT_BITS(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_w_en(id_w_en), .id_req_w(id_req_w), .id_lat(id_lat),
    .bubble(bubble), .fwd_sel(fwd_sel), .slot_valid(slot_valid),
    .stall_count(stall_count), .fwd_count(fwd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sel(input string tag);
    logic [5:0] exp;
    if (q_sel.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed=%0h expected=<queue empty>", tag, fwd_sel);
    end else begin
      exp = q_sel.pop_front();
      chk(tag, {26'd0, fwd_sel}, {26'd0, exp});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic we, input logic [4:0] d,
                       input logic [1:0] lat, input logic fl, input logic st,
                       input logic [5:0] exp_sel);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_w_en     = we;
    id_req_w    = d;
    id_lat      = lat;
    flush       = fl;
    stall_in    = st;
    q_sel.push_back(exp_sel);
    #1;
  endtask

  task automatic idle();
    instr(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 6'o00);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; stall_in = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_src = '0; id_src_used = '0; id_w_en = 1'b0; id_req_w = '0; id_lat = '0;
    #3;
    chk("rst_slot_valid", {29'd0, slot_valid}, 32'd0);
    chk("rst_fwd_sel", {26'd0, fwd_sel}, 32'd0);
    chk("rst_stall_count", {28'd0, stall_count}, 32'd0);
    chk("rst_fwd_count", {28'd0, fwd_count}, 32'd0);
    tick();
    rst = 1'b0;

    // Back-to-back ALU: addu $3,$1,$2 ; addu $4,$3,$3
    instr(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 6'o00);
    chk("alu1_bubble", {31'd0, bubble}, 32'd0);
    tick(); chk_sel("alu1_sel");
    instr(1'b1, 5'd3, 5'd3, 2'b11, 1'b1, 5'd4, 2'd1, 1'b0, 1'b0, 6'o22);
    chk("alu2_bubble", {31'd0, bubble}, 32'd0);
    tick(); chk_sel("alu2_sel");
    chk("alu2_fwd_count", {28'd0, fwd_count}, 32'd1);
    chk("alu2_slot_valid", {29'd0, slot_valid}, 32'b011);
    idle(); tick(); chk_sel("idle1_sel");
    idle(); tick(); chk_sel("idle2_sel");

    // Load-use: lw $5,0($0) ; addu $6,$5,$0 (bubble then retry)
    instr(1'b1, 5'd0, 5'd0, 2'b01, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, 6'o00);
    tick(); chk_sel("lw_sel");
    instr(1'b1, 5'd5, 5'd0, 2'b11, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 6'o00);
    chk("lu_bubble", {31'd0, bubble}, 32'd1);
    tick(); chk_sel("lu_sel");
    chk("lu_stall_count", {28'd0, stall_count}, 32'd1);
    chk("lu_slot_valid", {29'd0, slot_valid}, 32'b010);
    instr(1'b1, 5'd5, 5'd0, 2'b11, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 6'o03);
    chk("retry_bubble", {31'd0, bubble}, 32'd0);
    tick(); chk_sel("retry_sel");
    chk("retry_fwd_count", {28'd0, fwd_count}, 32'd2);
    chk("retry_stall_count", {28'd0, stall_count}, 32'd1);
    chk("retry_slot_valid", {29'd0, slot_valid}, 32'b101);

    // Youngest wins, and a $0 writer never matches
    instr(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd7, 2'd1, 1'b0, 1'b0, 6'o00);
    tick(); chk_sel("w7a_sel");
    instr(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd7, 2'd1, 1'b0, 1'b0, 6'o00);
    tick(); chk_sel("w7b_sel");
    instr(1'b1, 5'd7, 5'd0, 2'b11, 1'b1, 5'd0, 2'd1, 1'b0, 1'b0, 6'o02);
    tick(); chk_sel("youngest_sel");
    chk("youngest_fwd_count", {28'd0, fwd_count}, 32'd3);
    instr(1'b1, 5'd0, 5'd7, 2'b11, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0, 6'o30);
    tick(); chk_sel("r0_skip_sel");
    chk("r0_fwd_count", {28'd0, fwd_count}, 32'd4);
    // Unused source must not forward even though it matches slot 1
    instr(1'b1, 5'd9, 5'd1, 2'b10, 1'b1, 5'd10, 2'd1, 1'b0, 1'b0, 6'o00);
    tick(); chk_sel("mask_sel");
    chk("mask_fwd_count", {28'd0, fwd_count}, 32'd4);
    idle(); tick(); chk_sel("idle3_sel");
    idle(); tick(); chk_sel("idle4_sel");

    // Flush during hazard, then external stall
    instr(1'b1, 5'd0, 5'd0, 2'b01, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, 6'o00);
    tick(); chk_sel("lw2_sel");
    instr(1'b1, 5'd5, 5'd0, 2'b11, 1'b1, 5'd6, 2'd1, 1'b1, 1'b0, 6'o00);
    chk("flush_bubble", {31'd0, bubble}, 32'd0);
    tick(); chk_sel("flush_sel");
    chk("flush_slot_valid", {29'd0, slot_valid}, 32'b010);
    chk("flush_stall_count", {28'd0, stall_count}, 32'd1);
    instr(1'b1, 5'd5, 5'd0, 2'b11, 1'b1, 5'd6, 2'd1, 1'b0, 1'b1, 6'o00);
    chk("stall_bubble", {31'd0, bubble}, 32'd0);
    tick(); chk_sel("stall_sel");
    chk("stall_slot_valid", {29'd0, slot_valid}, 32'b100);
    chk("stall_fwd_count", {28'd0, fwd_count}, 32'd4);

    // Freeze: build state, then hold en=0 for 4 cycles with a hazard in ID
    instr(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd11, 2'd1, 1'b0, 1'b0, 6'o00);
    tick(); chk_sel("a11_sel");
    instr(1'b1, 5'd11, 5'd11, 2'b01, 1'b1, 5'd12, 2'd2, 1'b0, 1'b0, 6'o02);
    tick(); chk_sel("lw12_sel");
    chk("lw12_fwd_count", {28'd0, fwd_count}, 32'd5);
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      instr(1'b1, 5'd12, 5'd0, 2'b11, 1'b1, 5'd13, 2'd1, 1'b0, 1'b0, 6'o02);
      chk("frz_bubble", {31'd0, bubble}, 32'd1);
      tick(); chk_sel("frz_sel");
      chk("frz_slot_valid", {29'd0, slot_valid}, 32'b011);
      chk("frz_stall_count", {28'd0, stall_count}, 32'd1);
      chk("frz_fwd_count", {28'd0, fwd_count}, 32'd5);
    end

    // Asynchronous reset mid-cycle, no clock edge in between
    rst = 1'b1;
    #1;
    chk("arst_slot_valid", {29'd0, slot_valid}, 32'd0);
    chk("arst_fwd_sel", {26'd0, fwd_sel}, 32'd0);
    chk("arst_stall_count", {28'd0, stall_count}, 32'd0);
    chk("arst_fwd_count", {28'd0, fwd_count}, 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    q_sel.delete();
    instr(1'b1, 5'd12, 5'd11, 2'b11, 1'b1, 5'd14, 2'd1, 1'b0, 1'b0, 6'o00);
    chk("post_rst_bubble", {31'd0, bubble}, 32'd0);
    tick(); chk_sel("post_rst_sel");
    chk("post_rst_slot_valid", {29'd0, slot_valid}, 32'b001);

    // Saturation: 20 load-use bubbles, 19 forwarding issues, 4-bit counters
    for (int n = 0; n < 20; n++) begin
      instr(1'b1, 5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, (n == 0) ? 6'o00 : 6'o03);
      chk("sat_lw_bubble", {31'd0, bubble}, 32'd0);
      tick(); chk_sel("sat_lw_sel");
      instr(1'b1, 5'd5, 5'd0, 2'b11, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 6'o00);
      chk("sat_use_bubble", {31'd0, bubble}, 32'd1);
      tick(); chk_sel("sat_use_sel");
      chk("sat_stall_count", {28'd0, stall_count}, (n + 1 > 15) ? 32'd15 : 32'(n + 1));
    end
    chk("sat_fwd_count", {28'd0, fwd_count}, 32'd15);
    idle(); tick(); chk_sel("sat_idle_sel");
    chk("sat_hold_stall_count", {28'd0, stall_count}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_hazard_scoreboard.md
Name: syn_hazard_scoreboard

Overview:
- Parametrised successor to the fixed EX/DM collision detector in the 5-stage MIPS pipeline.
- Tracks destination registers of in-flight instructions across a configurable number of post-ID slots.
- Produces registered per-source forwarding selects for EX, plus a combinational load-use bubble request.
- Supports N source operands, per-instruction result latency, flush, freeze, and saturating stall/forward event counters.

Parameters:
- SLOTS, 3, in-flight slots after ID (1=ID/EX, 2=EX/DM, 3=DM/WB); range 2..7.
- NUM_SRC, 2, source operands checked per instruction.
- REG_BITS, 5, register index width.
- SEL_BITS, 3, forwarding select width; must satisfy 2^SEL_BITS > SLOTS.
- CNT_BITS, 16, event counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  global enable; 0 freezes all state
- stall_in  in  1  external stall (halt); same effect as bubble
- flush  in  1  squash the instruction in ID (taken branch or jump)
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_BITS  source register indices; source i occupies bits [i*REG_BITS +: REG_BITS]
- id_src_used  in  NUM_SRC  per-source use mask
- id_w_en  in  1  ID instruction writes the register file
- id_req_w  in  REG_BITS  destination register
- id_lat  in  2  slots until the result is forwardable: 1=ALU or PC+4, 2=load
- bubble  out  1  combinational load-use stall request
- fwd_sel  out  NUM_SRC*SEL_BITS  registered select per source, valid while the instruction is in EX
- slot_valid  out  SLOTS  debug view of slot occupancy
- stall_count  out  CNT_BITS  cycles with bubble=1
- fwd_count  out  CNT_BITS  issued instructions with at least one nonzero select

Behaviour:
- Reset (async, immediate): all slots invalid, fwd_sel=0, both counters=0.
- Slot contents: {valid, w_en, dest, lat}. Slot 1 is the youngest entry.
- Match rule for source i at slot k, k=1..SLOTS-1: id_src_used[i], slot valid, slot w_en, dest==src, dest!=0.
  - Slot SLOTS is never matched; the register file writes first, so a WB producer is read directly.
- For each source, take the youngest match k:
  - No match: sel=0 (use register file data).
  - k < lat: hazard.
  - Otherwise: sel=k+1, meaning EX taps slot k+1's result register next cycle.
- Bubble: bubble = id_valid & any source hazard & !flush. Combinational, no registers in path.
- Advance on en=1 (one clock):
  - Slots k>1 take slot k-1; slot SLOTS contents drop off.
  - Slot 1 loads the ID instruction when id_valid & !bubble & !stall_in & !flush; otherwise slot 1 loads an invalid entry.
  - fwd_sel loads the computed selects when ID issues, else 0.
- Freeze: en=0 holds slots, fwd_sel and counters unchanged; bubble is still computed.
- Priority: rst > en=0 > flush > stall_in > bubble > issue.
- flush with a pending hazard: slot 1 gets an invalid entry and no bubble is raised.
- Simultaneous matches in several slots: the youngest slot wins.
- Counters:
  - stall_count increments on en & bubble.
  - fwd_count increments on issue with any sel!=0.
  - Both saturate at all-ones; neither wraps.
- Mid-operation reset: clears all slots asynchronously, so no stale forwarding after release.

Test Plan:
- Back-to-back ALU: addu $3 then addu $4,$3,$3 -> bubble=0, next cycle fwd_sel src0=src1=2, fwd_count=1.
- Load-use: lw $5 (lat=2) then addu $6,$5,$0 -> bubble=1 for exactly one cycle, stall_count=1, slot_valid=3'b010; retry gives sel=3.
- Youngest wins: addu $7 twice, then reader of $7 -> sel=2, not 3; a writer to $0 never matches (sel=0).
- Flush during hazard: lw $5, then reader of $5 with flush=1 -> bubble=0, slot_valid=3'b010, fwd_sel=0.
- Freeze and reset: en=0 for 4 cycles keeps slot_valid and fwd_sel constant; rst pulse mid-stream gives slot_valid=0 and counters=0 without waiting for a clock edge.
- Saturation with CNT_BITS=4: 20 consecutive bubble cycles -> stall_count=15 and holds there.
